// File: rtl/burst_line_adaptor.sv
// burst_line_adaptor: bridges a cache that moves one full line per request to a
// burst memory port that moves one BURST_W beat per cycle. Reads assemble the
// line beat by beat into line_o; writes latch the line and stream it out.
// A watchdog aborts a transaction whose memory side goes silent for too long.
//
// Handshakes:
//   LLC side    - read_i/write_i are levels held until the one-cycle resp_o
//                 pulse; err_o qualifies that pulse (1 = aborted by timeout).
//   memory side - read_o/write_o act as "valid" for the whole burst and
//                 resp_i is the per-beat "ready": a beat is transferred on
//                 every rising edge where the request and resp_i are both
//                 high. burst_o is stable while resp_i is low.
module burst_line_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  output logic               err_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i,
  output logic [1:0]         dbg_state
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  // Clears the byte-offset bits so the memory always sees a line address.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT   = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [WD_W-1:0]   wdog;
  logic              abort;
  logic [LINE_W-1:0] wbuf;
  logic              busy;
  logic              last_beat;
  logic              expired;

  assign busy      = (state == RD) || (state == WR);
  assign last_beat = busy && resp_i && (cnt == LAST_BEAT);
  // A beat arriving on the limit cycle wins over the timeout.
  assign expired   = busy && !resp_i && (TIMEOUT > 0) && (wdog == WD_LIMIT);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: reads win over writes when both are requested.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (read_i)       state_nxt = RD;
        else if (write_i) state_nxt = WR;
      end
      RD, WR: begin
        if (last_beat || expired) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; the write beat follows cnt combinationally.
  always_comb begin
    read_o    = (state == RD);
    write_o   = (state == WR);
    resp_o    = (state == DONE);
    err_o     = (state == DONE) && abort;
    burst_o   = '0;
    if (state == WR) burst_o = wbuf[int'(cnt) * BURST_W +: BURST_W];
    dbg_state = state;
  end

  // Datapath: request latching, beat counting, line assembly and watchdog.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      wdog      <= '0;
      abort     <= 1'b0;
      line_o    <= '0;
      wbuf      <= '0;
      address_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt   <= '0;
          wdog  <= '0;
          abort <= 1'b0;
          if (read_i || write_i) begin
            address_o <= address_i & ALIGN_MASK;
            if (!read_i) wbuf <= line_i;
          end
        end
        RD, WR: begin
          if (resp_i) begin
            cnt  <= cnt + CNT_W'(1);
            wdog <= '0;
            if (state == RD) line_o[int'(cnt) * BURST_W +: BURST_W] <= burst_i;
          end else if (expired) begin
            abort <= 1'b1;
          end else if (TIMEOUT > 0) begin
            wdog <= wdog + WD_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          wdog  <= '0;
          abort <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_line_adaptor.sv
// Bench for burst_line_adaptor: a 256/64 instance with a short watchdog and a
// 512/128 instance with the watchdog disabled.
module tb_burst_line_adaptor;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- 256/64 instance ----------------
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o, err_o, read_o, write_o, resp_i;
  logic [63:0]  burst_i, burst_o;
  logic [1:0]   dbg_state;

  burst_line_adaptor #(.LINE_W(256), .BURST_W(64), .ADDR_W(32), .TIMEOUT(8)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .resp_o(resp_o), .err_o(err_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i),
    .dbg_state(dbg_state)
  );

  // ---------------- 512/128 instance ----------------
  logic [511:0] w_line_i, w_line_o;
  logic [31:0]  w_address_i, w_address_o;
  logic         w_read_i, w_write_i, w_resp_o, w_err_o, w_read_o, w_write_o, w_resp_i;
  logic [127:0] w_burst_i, w_burst_o;
  logic [1:0]   w_dbg_state;

  burst_line_adaptor #(.LINE_W(512), .BURST_W(128), .ADDR_W(32), .TIMEOUT(0)) u_wide (
    .clk(clk), .reset_n(reset_n),
    .line_i(w_line_i), .line_o(w_line_o),
    .address_i(w_address_i), .read_i(w_read_i), .write_i(w_write_i),
    .resp_o(w_resp_o), .err_o(w_err_o),
    .burst_i(w_burst_i), .burst_o(w_burst_o), .address_o(w_address_o),
    .read_o(w_read_o), .write_o(w_write_o), .resp_i(w_resp_i),
    .dbg_state(w_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int vectors;
  int miscompares;
  // {is_read, err, line}
  logic [257:0] exp_q[$];
  logic [63:0]  beat_q[$];
  logic [511:0] wide_q[$];
  logic [257:0] mon_e;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Completion and write-beat monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (resp_o) begin
        check("sb_pending", 512'(exp_q.size() > 0), 512'(1));
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("err_o", 512'(err_o), 512'(mon_e[256]));
          if (mon_e[257] && !mon_e[256]) check("line_o", 512'(line_o), 512'(mon_e[255:0]));
        end
      end
      if (write_o && resp_i) begin
        check("beat_pending", 512'(beat_q.size() > 0), 512'(1));
        if (beat_q.size() > 0) check("burst_o", 512'(burst_o), 512'(beat_q.pop_front()));
      end
      if (w_resp_o) begin
        check("w_pending", 512'(wide_q.size() > 0), 512'(1));
        check("w_err_o", 512'(w_err_o), 512'(0));
        if (wide_q.size() > 0) check("w_line_o", w_line_o, wide_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [15:0] rand_gaps(input int max_gap);
    logic [15:0] g;
    for (int k = 0; k < 4; k++) g[4*k +: 4] = 4'($urandom_range(0, max_gap));
    return g;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  // Waits (bounded) for resp_o, then checks latency from the request cycle.
  task automatic wait_done(input int t0, input int lat);
    int waited;
    waited = 0;
    while (!resp_o && waited < 32) begin
      @(posedge clk); #1;
      waited++;
    end
    check("resp_latency", 512'(cyc - t0), 512'(lat));
    check("req_drop", 512'({read_o, write_o}), 512'(0));
  endtask

  task automatic read_txn(input logic [31:0] addr, input logic [255:0] line,
                          input logic [15:0] gaps, input bit hold_write);
    int t0, n;
    @(posedge clk); #1;
    read_i = 1'b1;
    address_i = addr;
    if (hold_write) write_i = 1'b1;
    exp_q.push_back({1'b1, 1'b0, line});
    t0 = cyc;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < int'(gaps[4*k +: 4]); g++) begin
        @(posedge clk); #1;
        check("rd_req_stall", 512'(read_o), 512'(1));
        resp_i = 1'b0;
        burst_i = {$urandom, $urandom};
        n++;
      end
      @(posedge clk); #1;
      check("rd_req", 512'({write_o, read_o}), 512'(2'b01));
      if (k == 0) check("rd_addr", 512'(address_o), 512'(addr & ~32'h1F));
      resp_i = 1'b1;
      burst_i = line[64*k +: 64];
      n++;
    end
    @(posedge clk); #1;
    resp_i = 1'b0;
    burst_i = {$urandom, $urandom};
    wait_done(t0, n + 1);
    read_i = 1'b0;
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [255:0] line,
                           input logic [15:0] gaps);
    int t0, n;
    @(posedge clk); #1;
    write_i = 1'b1;
    address_i = addr;
    line_i = line;
    exp_q.push_back({1'b0, 1'b0, 256'h0});
    for (int k = 0; k < 4; k++) beat_q.push_back(line[64*k +: 64]);
    t0 = cyc;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < int'(gaps[4*k +: 4]); g++) begin
        @(posedge clk); #1;
        check("wr_stall", 512'({write_o, burst_o}), 512'({1'b1, line[64*k +: 64]}));
        resp_i = 1'b0;
        line_i = rand_line();
        n++;
      end
      @(posedge clk); #1;
      check("wr_req", 512'({read_o, write_o}), 512'(2'b01));
      if (k == 0) check("wr_addr", 512'(address_o), 512'(addr & ~32'h1F));
      resp_i = 1'b1;
      line_i = rand_line();
      n++;
    end
    @(posedge clk); #1;
    resp_i = 1'b0;
    wait_done(t0, n + 1);
    write_i = 1'b0;
  endtask

  // Memory never answers: the watchdog must end the read with err_o.
  task automatic read_silent(input logic [31:0] addr);
    int t0;
    @(posedge clk); #1;
    read_i = 1'b1;
    address_i = addr;
    exp_q.push_back({1'b1, 1'b1, 256'h0});
    t0 = cyc;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      check("to_req_held", 512'(read_o), 512'(1));
    end
    @(posedge clk); #1;
    wait_done(t0, 10);
    read_i = 1'b0;
  endtask

  task automatic wide_read(input logic [31:0] addr, input logic [511:0] line,
                           input logic [15:0] gaps);
    int t0, n, waited;
    @(posedge clk); #1;
    w_read_i = 1'b1;
    w_address_i = addr;
    wide_q.push_back(line);
    t0 = cyc;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < int'(gaps[4*k +: 4]); g++) begin
        @(posedge clk); #1;
        check("w_req_stall", 512'(w_read_o), 512'(1));
        w_resp_i = 1'b0;
        n++;
      end
      @(posedge clk); #1;
      check("w_req", 512'(w_read_o), 512'(1));
      if (k == 0) check("w_addr", 512'(w_address_o), 512'(addr & ~32'h3F));
      w_resp_i = 1'b1;
      w_burst_i = line[128*k +: 128];
      n++;
    end
    @(posedge clk); #1;
    w_resp_i = 1'b0;
    waited = 0;
    while (!w_resp_o && waited < 32) begin
      @(posedge clk); #1;
      waited++;
    end
    check("w_latency", 512'(cyc - t0), 512'(n + 1));
    w_read_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [255:0] l0, l1;
  logic [511:0] wl;

  initial begin
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    reset_n = 1'b0;
    line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    w_line_i = '0; w_address_i = '0; w_read_i = 1'b0; w_write_i = 1'b0;
    w_burst_i = '0; w_resp_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 512'({read_o, write_o, resp_o, err_o, dbg_state}), 512'(0));
    check("rst_burst_o", 512'(burst_o), 512'(0));
    check("rst_address_o", 512'(address_o), 512'(0));
    check("rst_line_o", 512'(line_o), 512'(0));
    check("rst_w_line_o", w_line_o, 512'(0));
    reset_n = 1'b1;

    // Directed gapless read.
    l0 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    l0 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    read_txn(32'h0000_1234, l0, 16'h0000, 1'b0);

    // Directed write with strobes 1,0,0,1,1,0,1.
    l1 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    write_txn(32'hABCD_0047, l1, 16'h1020);

    // Read and write requested together: read first, then the held write.
    read_txn(32'h0000_8008, rand_line(), rand_gaps(2), 1'b1);
    write_txn(32'h0000_9010, rand_line(), 16'h0000);

    // Silent memory, then a normal read to show the abort flag is cleared.
    read_silent(32'h0000_0100);
    read_txn(32'h0000_0140, rand_line(), rand_gaps(3), 1'b0);

    // Reset in the middle of a write, after two beats.
    @(posedge clk); #1;
    write_i = 1'b1;
    address_i = 32'h0000_2000;
    line_i = l1;
    beat_q.push_back(l1[63:0]);
    beat_q.push_back(l1[127:64]);
    @(posedge clk); #1;
    resp_i = 1'b1;
    @(posedge clk); #1;
    resp_i = 1'b1;
    @(posedge clk); #1;
    resp_i = 1'b0;
    check("rst_mid_beat2", 512'({write_o, burst_o}), 512'({1'b1, l1[191:128]}));
    reset_n = 1'b0;
    #1;
    check("rst_mid_ctrl", 512'({write_o, resp_o, burst_o}), 512'(0));
    check("rst_mid_line_o", 512'(line_o), 512'(0));
    write_i = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    read_txn(32'h0000_3000, rand_line(), 16'h0000, 1'b0);

    // Mixed random traffic.
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1)
        read_txn($urandom, rand_line(), rand_gaps(3), 1'b0);
      else
        write_txn($urandom, rand_line(), rand_gaps(3));
    end

    // Wide instance: gapless and long gaps (watchdog disabled).
    wl = {rand_line(), rand_line()};
    wide_read(32'h1234_5678, wl, 16'h0000);
    wl = {rand_line(), rand_line()};
    wide_read(32'h0000_00C1, wl, rand_gaps(15));

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 512'(exp_q.size() + beat_q.size() + wide_q.size()), 512'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

endmodule
